pc_tx_word_serialiser: RTL and testbench
========================================

# pc_tx_word_serialiser

Converts 32-bit words from the data router into a framed byte stream for the PC-side UART transmitter. It sits between the router's output word interface and the UART TX byte interface. For each accepted word it emits a start-of-frame byte, then the four data bytes, then an optional checksum byte. It exports the busy flag the router uses to pace words.

## Interface
Parameters:
- SOF_BYTE, 8'hA5: start-of-frame byte emitted before every word.
- MSB_FIRST, 1: 1 = data byte [31:24] first; 0 = byte [7:0] first.

Ports:
- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_word  input  32  word to transmit; sampled only on an accepted command.
- i_word_next_cmd  input  1  one-cycle pulse requesting transmission of i_word.
- o_busy  output  1  high while a frame is in progress; drives the router's serial-busy input.
- o_tx_byte  output  8  byte offered to the UART TX.
- o_tx_valid  output  1  o_tx_byte is valid.
- i_tx_ready  input  1  UART TX can take a byte this cycle.
- o_frame_done  output  1  one-cycle pulse after the final byte of a frame is accepted.
- o_drop_count  output  8  saturating count of commands rejected while busy.

## Operation
- States: IDLE, SOF, DATA, CSUM. CSUM exists only with PC_TX_CHECKSUM_EN.
- IDLE, i_word_next_cmd=1: latch i_word into the holding register, clear the checksum accumulator and byte index, go to SOF.
- Byte transfer occurs on a rising edge where o_tx_valid=1 and i_tx_ready=1.
- While o_tx_valid=1, o_tx_byte is held stable until it is transferred.
- SOF: o_tx_byte=SOF_BYTE. On transfer, go to DATA with index 0.
- DATA: o_tx_byte = holding-register byte selected by index and MSB_FIRST.
  - On transfer, XOR the byte into the accumulator and increment the 2-bit index.
  - On transfer at index 3: go to CSUM if enabled, else IDLE.
- CSUM: o_tx_byte = accumulator, which is the XOR of the 4 data bytes; SOF is excluded. On transfer, go to IDLE.
- o_frame_done pulses on the cycle after the final byte is transferred, coincident with the return to IDLE.
- o_busy = (state != IDLE). o_tx_valid = (state != IDLE).
- i_word_next_cmd while state != IDLE: command ignored, holding register unchanged, o_drop_count increments.
  - o_drop_count saturates at 8'hFF.
  - This includes the cycle in which the final byte is transferred.
- Changes to i_word after acceptance have no effect on the frame in progress.

## Timing
- Reset (i_reset_n=0, asynchronous): state IDLE, o_busy=0, o_tx_valid=0, o_tx_byte=8'h00, o_frame_done=0, o_drop_count=0, holding register and accumulator cleared.
  - Reset mid-frame abandons the frame; no further bytes are emitted.
- Command accepted at edge N: o_busy=1, o_tx_valid=1, o_tx_byte=SOF_BYTE from edge N.
- i_tx_ready held high: one byte per cycle, back-to-back.
  - Frame occupies 5 cycles, or 6 with checksum.
  - o_busy falls and o_frame_done pulses on the edge after the last transfer.
- A new command is accepted on the first IDLE cycle, so a frame may start on the same cycle o_frame_done is high.
- i_tx_ready low: state and o_tx_byte hold indefinitely; there is no timeout.

## Configuration
- PC_TX_CHECKSUM_EN defined: CSUM state is present; frames are 6 bytes (SOF, 4 data bytes, XOR checksum).
- PC_TX_CHECKSUM_EN undefined: CSUM state and accumulator are removed; frames are 5 bytes; DATA index 3 transfer returns to IDLE.

## Test plan
- Reset release, no commands: o_busy=0, o_tx_valid=0, o_tx_byte=00, o_drop_count=00 for 20 cycles.
- i_word=32'h12345678, MSB_FIRST=1, ready always high, checksum enabled: bytes A5,12,34,56,78,08 on consecutive cycles. o_frame_done pulses once; o_busy high for exactly 6 cycles.
- Same word, MSB_FIRST=0, checksum disabled: bytes A5,78,56,34,12; o_busy high for 5 cycles.
- i_tx_ready toggled 1-0-0-1 randomly: every byte is held stable while ready=0. The byte sequence is identical to the ready-high case, and i_word changes mid-frame do not alter it.
- Commands pulsed 300 times while a stalled frame is in progress: o_drop_count=FF with no wrap; the frame in progress is unaffected.
- i_reset_n pulsed low after the second data byte: outputs return to reset values immediately; the next command emits a complete fresh frame starting with A5.

Source files
------------

// File: rtl/pc_tx_word_serialiser.sv
// Frames 32-bit router words into SOF + 4 data bytes (+ optional XOR checksum) for the PC UART TX.
// Optional checksum byte: define PC_TX_CHECKSUM_EN.
module pc_tx_word_serialiser #(
   parameter logic [7:0] SOF_BYTE  = 8'hA5,
   parameter bit         MSB_FIRST = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [31:0] i_word,
   input  logic        i_word_next_cmd,
   output logic        o_busy,
   output logic [7:0]  o_tx_byte,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_frame_done,
   output logic [7:0]  o_drop_count
);

`ifdef PC_TX_CHECKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SOF  = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SOF  = 2'd1,
      ST_DATA = 2'd2
   } state_t;
`endif

   state_t      state_r;
   logic [31:0] hold_r;
   logic [1:0]  idx_r;
   logic [7:0]  tx_byte_r;
   logic        busy_r;
   logic        frame_done_r;
   logic [7:0]  drop_count_r;
`ifdef PC_TX_CHECKSUM_EN
   logic [7:0]  acc_r;
`endif

   // Byte of the holding register for a given wire-order index.
   function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [1:0] pos_s;
      logic [7:0] byte_s;
      pos_s = MSB_FIRST ? (2'd3 - idx) : idx;
      case (pos_s)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = 8'h00;
      endcase
      return byte_s;
   endfunction

   // Frame sequencer; tx_byte_r always holds the byte of the current state so it is stable until taken.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r      <= ST_IDLE;
         hold_r       <= 32'h0000_0000;
         idx_r        <= 2'd0;
         tx_byte_r    <= 8'h00;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
`ifdef PC_TX_CHECKSUM_EN
         acc_r        <= 8'h00;
`endif
      end else begin
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_word_next_cmd) begin
                  hold_r    <= i_word;
                  idx_r     <= 2'd0;
`ifdef PC_TX_CHECKSUM_EN
                  acc_r     <= 8'h00;
`endif
                  tx_byte_r <= SOF_BYTE;
                  busy_r    <= 1'b1;
                  state_r   <= ST_SOF;
               end
            end
            ST_SOF: begin
               if (i_tx_ready) begin
                  idx_r     <= 2'd0;
                  tx_byte_r <= sel_byte(hold_r, 2'd0);
                  state_r   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (i_tx_ready) begin
                  idx_r <= idx_r + 2'd1;
`ifdef PC_TX_CHECKSUM_EN
                  acc_r <= acc_r ^ tx_byte_r;
`endif
                  if (idx_r == 2'd3) begin
`ifdef PC_TX_CHECKSUM_EN
                     tx_byte_r <= acc_r ^ tx_byte_r;
                     state_r   <= ST_CSUM;
`else
                     tx_byte_r    <= 8'h00;
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
                     state_r      <= ST_IDLE;
`endif
                  end else begin
                     tx_byte_r <= sel_byte(hold_r, idx_r + 2'd1);
                  end
               end
            end
`ifdef PC_TX_CHECKSUM_EN
            ST_CSUM: begin
               if (i_tx_ready) begin
                  tx_byte_r    <= 8'h00;
                  busy_r       <= 1'b0;
                  frame_done_r <= 1'b1;
                  state_r      <= ST_IDLE;
               end
            end
`endif
            default: begin
               tx_byte_r <= 8'h00;
               busy_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of commands that arrive while a frame is in flight.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         drop_count_r <= 8'h00;
      end else if (i_word_next_cmd && (state_r != ST_IDLE) && (drop_count_r != 8'hFF)) begin
         drop_count_r <= drop_count_r + 8'd1;
      end
   end

   assign o_busy       = busy_r;
   assign o_tx_valid   = busy_r;
   assign o_tx_byte    = tx_byte_r;
   assign o_frame_done = frame_done_r;
   assign o_drop_count = drop_count_r;

endmodule

// File: tb/tb_pc_tx_word_serialiser.sv
// Directed bench for pc_tx_word_serialiser: MSB-first and LSB-first instances driven in lockstep.
module tb_pc_tx_word_serialiser;

`ifdef PC_TX_CHECKSUM_EN
   localparam int N_BYTES = 6;
`else
   localparam int N_BYTES = 5;
`endif

   logic        i_clock = 1'b0;
   logic        i_reset_n = 1'b0;
   logic [31:0] i_word = 32'h0;
   logic        i_word_next_cmd = 1'b0;
   logic        i_tx_ready = 1'b1;
   logic        busy_a, valid_a, done_a, busy_b, valid_b, done_b;
   logic [7:0]  byte_a, drop_a, byte_b, drop_b;
   logic [7:0]  exp_a [6];
   logic [7:0]  exp_b [6];
   int          errors = 0;
   int          checks = 0;

   always #5 i_clock = ~i_clock;

   pc_tx_word_serialiser u_dut_msb (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_word(i_word), .i_word_next_cmd(i_word_next_cmd),
      .o_busy(busy_a), .o_tx_byte(byte_a), .o_tx_valid(valid_a), .i_tx_ready(i_tx_ready),
      .o_frame_done(done_a), .o_drop_count(drop_a));

   pc_tx_word_serialiser #(.MSB_FIRST(1'b0)) u_dut_lsb (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .i_word(i_word), .i_word_next_cmd(i_word_next_cmd),
      .o_busy(busy_b), .o_tx_byte(byte_b), .o_tx_valid(valid_b), .i_tx_ready(i_tx_ready),
      .o_frame_done(done_b), .o_drop_count(drop_b));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Reference byte at frame position pos for a given byte order.
   function automatic logic [7:0] model_byte(input logic [31:0] w, input bit msb, input int pos);
      int d;
      if (pos == 0) return 8'hA5;
      if (pos == 5) return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      d = msb ? (4 - pos) : (pos - 1);
      return w[8*d +: 8];
   endfunction

   task automatic load_exp(input logic [31:0] w);
      for (int p = 0; p < 6; p++) begin
         exp_a[p] = model_byte(w, 1'b1, p);
         exp_b[p] = model_byte(w, 1'b0, p);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_busy"}, 32'(busy_a), 32'd0);
      check_val({tag, "_valid"}, 32'(valid_a), 32'd0);
      check_val({tag, "_byte"}, 32'(byte_a), 32'h00);
      check_val({tag, "_busy_lsb"}, 32'(busy_b), 32'd0);
   endtask

   // Called at a negedge; the command is taken on the following posedge.
   task automatic start_frame(input logic [31:0] w);
      i_word = w;
      i_word_next_cmd = 1'b1;
      @(negedge i_clock);
      i_word_next_cmd = 1'b0;
   endtask

   // mode 0: ready high; 1: random ready and word churn; 2: ready high plus a command on the last transfer.
   task automatic drain(input int mode);
      int  k = 0;
      int  cyc = 0;
      logic r;
      while (k < N_BYTES && cyc < 400) begin
         check_val("busy", 32'(busy_a), 32'd1);
         check_val("valid", 32'(valid_a), 32'd1);
         check_val("byte_msb", 32'(byte_a), 32'(exp_a[k]));
         check_val("byte_lsb", 32'(byte_b), 32'(exp_b[k]));
         if (mode == 1) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            i_word = $urandom;
         end else begin
            i_tx_ready = 1'b1;
         end
         if (mode == 2 && k == N_BYTES - 1) i_word_next_cmd = 1'b1;
         r = i_tx_ready;
         @(posedge i_clock);
         @(negedge i_clock);
         i_word_next_cmd = 1'b0;
         if (r) k++;
         cyc++;
      end
      i_tx_ready = 1'b1;
      check_val("frame_len", 32'(k), 32'(N_BYTES));
      if (mode != 1) check_val("frame_cycles", 32'(cyc), 32'(N_BYTES));
      check_val("end_busy", 32'(busy_a), 32'd0);
      check_val("end_valid", 32'(valid_b), 32'd0);
      check_val("end_done_msb", 32'(done_a), 32'd1);
      check_val("end_done_lsb", 32'(done_b), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge i_clock);
      check_idle_outputs("in_reset");
      i_reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge i_clock);
         check_idle_outputs("post_reset");
         check_val("post_reset_drop", 32'(drop_a), 32'h00);
      end

      // Frame 1: 12345678 with ready always high.
      exp_a = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      exp_b = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      start_frame(32'h1234_5678);
      drain(0);
      check_val("f1_drop", 32'(drop_a), 32'h00);
      @(negedge i_clock);
      check_val("done_one_cycle", 32'(done_a), 32'd0);
      check_idle_outputs("f1_idle");

      // Frame 2: same word, random stalls and i_word churn.
      start_frame(32'h1234_5678);
      drain(1);
      @(negedge i_clock);

      // Frame 3: command on final transfer is dropped; next frame starts on the done cycle.
      load_exp(32'hDEAD_BEEF);
      start_frame(32'hDEAD_BEEF);
      drain(2);
      check_val("last_cycle_drop", 32'(drop_a), 32'h01);
      load_exp(32'hCAFE_F00D);
      start_frame(32'hCAFE_F00D);
      drain(0);
      check_val("f4_drop", 32'(drop_b), 32'h01);
      @(negedge i_clock);

      // Saturation: 300 commands against a stalled frame.
      load_exp(32'h0F1E_2D3C);
      i_tx_ready = 1'b0;
      start_frame(32'h0F1E_2D3C);
      for (int p = 0; p < 300; p++) begin
         i_word_next_cmd = 1'b1;
         i_word = $urandom;
         @(negedge i_clock);
         i_word_next_cmd = 1'b0;
         @(negedge i_clock);
      end
      check_val("drop_sat_msb", 32'(drop_a), 32'hFF);
      check_val("drop_sat_lsb", 32'(drop_b), 32'hFF);
      check_val("stall_byte", 32'(byte_a), 32'hA5);
      drain(0);
      @(negedge i_clock);

      // Reset after the second data byte, then a fresh frame.
      load_exp(32'h8899_AABB);
      start_frame(32'h8899_AABB);
      repeat (3) @(negedge i_clock);
      check_val("pre_rst_byte", 32'(byte_a), 32'(exp_a[3]));
      i_reset_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      check_val("async_rst_drop", 32'(drop_a), 32'h00);
      check_val("async_rst_done", 32'(done_a), 32'd0);
      @(negedge i_clock);
      i_reset_n = 1'b1;
      @(negedge i_clock);
      check_idle_outputs("after_rst");
      load_exp(32'h0123_4567);
      start_frame(32'h0123_4567);
      drain(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
